// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and system reset release on the reference clock.
// All outputs are registered from the next state; lock decisions see pll_lock after SYNC_STAGES flops.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             sw_reset_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [1:0]       state_dbg
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_nx;
  logic [CYC_W-1:0]       cyc_q;
  logic [CYC_W-1:0]       cyc_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   loss_evt;
  logic                   tmo_evt;

  // pll_lock is asynchronous to clk_in; only the last stage is ever looked at
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nx = state_q;
    cyc_nx   = cyc_q + 1'b1;
    loss_evt = 1'b0;
    tmo_evt  = 1'b0;

    unique case (state_q)
      ST_PLL_RST: begin
        if (cyc_q == RST_LAST) begin
          state_nx = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = ST_STABLE;
        end else if (cyc_q == TMO_LAST) begin
          state_nx = ST_PLL_RST;
          tmo_evt  = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
        end else if (cyc_q == STB_LAST) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_nx = '0;
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_nx = ST_PLL_RST;
      end
    endcase

    // A software request beats any lock or timeout decision made this cycle
    if (sw_reset_req) begin
      state_nx = ST_PLL_RST;
      loss_evt = 1'b0;
      tmo_evt  = 1'b0;
    end

    if ((state_nx != state_q) || sw_reset_req) begin
      cyc_nx = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= ST_PLL_RST;
      cyc_q   <= '0;
    end else begin
      state_q <= state_nx;
      cyc_q   <= cyc_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      state_dbg <= 2'd0;
    end else begin
      pll_rst   <= (state_nx == ST_PLL_RST);
      sys_rst_n <= (state_nx == ST_RUN);
      ready     <= (state_nx == ST_RUN);
      state_dbg <= state_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      if (loss_evt && (lock_loss_cnt != {CNT_W{1'b1}})) begin
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
      if (tmo_evt && (timeout_cnt != {CNT_W{1'b1}})) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; expectations queued at stimulus time, popped at each check.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             pll_lock;
  logic             sw_reset_req;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [CNT_W-1:0] timeout_cnt;
  logic [1:0]       state_dbg;

  logic [31:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #20 clk_in = ~clk_in;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (2),
    .CNT_W         (CNT_W)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .sw_reset_req (sw_reset_req),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_cnt  (timeout_cnt),
    .state_dbg    (state_dbg)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  // Clock edges until the chosen output reaches val; stops at 200 so a stuck DUT shows as a bad count
  task automatic run_until(input bit sel_sys, input logic val, output int n, output bit saw_pll_rst);
    n = 0;
    saw_pll_rst = 1'b0;
    while (((sel_sys ? sys_rst_n : pll_rst) !== val) && (n < 200)) begin
      tick();
      n++;
      if (pll_rst !== 1'b0) saw_pll_rst = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    logic [31:0] exp_tmo;

    rst_n        = 1'b0;
    pll_lock     = 1'b1;
    sw_reset_req = 1'b0;
    tick();
    tick();

    // reset values
    expect_val(1); check("rst_pll_rst", pll_rst);
    expect_val(0); check("rst_sys_rst_n", sys_rst_n);
    expect_val(0); check("rst_ready", ready);
    expect_val(0); check("rst_state", state_dbg);
    expect_val(0); check("rst_loss_cnt", lock_loss_cnt);
    expect_val(0); check("rst_tmo_cnt", timeout_cnt);

    // 1: power-up with lock already present
    rst_n = 1'b1;
    expect_val(4);
    run_until(1'b0, 1'b0, n, saw);
    check("s1_pll_rst_width", n);
    expect_val(1); check("s1_state_wait", state_dbg);
    expect_val(9);
    expect_val(0);
    run_until(1'b1, 1'b1, n, saw);
    check("s1_release_latency", n);
    check("s1_no_pll_rst", saw);
    expect_val(1); check("s1_ready", ready);
    expect_val(3); check("s1_state_run", state_dbg);
    expect_val(0); check("s1_loss_cnt", lock_loss_cnt);
    expect_val(0); check("s1_tmo_cnt", timeout_cnt);

    // 4: three-cycle lock drop while running
    pll_lock = 1'b0;
    tick();
    tick();
    expect_val(1); check("s4_sys_still_up", sys_rst_n);
    tick();
    expect_val(0); check("s4_sys_drop", sys_rst_n);
    expect_val(0); check("s4_ready_drop", ready);
    expect_val(1); check("s4_state_wait", state_dbg);
    expect_val(1); check("s4_loss_cnt", lock_loss_cnt);
    expect_val(0); check("s4_no_pll_rst", pll_rst);
    pll_lock = 1'b1;
    expect_val(11);
    expect_val(0);
    run_until(1'b1, 1'b1, n, saw);
    check("s4_rerelease", n);
    check("s4_no_pll_rst_during", saw);
    expect_val(1); check("s4_loss_cnt_hold", lock_loss_cnt);

    // 5: software request coincident with a lock drop
    sw_reset_req = 1'b1;
    pll_lock     = 1'b0;
    tick();
    sw_reset_req = 1'b0;
    pll_lock     = 1'b1;
    expect_val(0); check("s5_state_pll_rst", state_dbg);
    expect_val(1); check("s5_pll_rst", pll_rst);
    expect_val(0); check("s5_sys_rst_n", sys_rst_n);
    expect_val(4);
    run_until(1'b0, 1'b0, n, saw);
    check("s5_pll_rst_width", n);
    expect_val(9);
    run_until(1'b1, 1'b1, n, saw);
    check("s5_release_latency", n);
    expect_val(1); check("s5_loss_cnt_unchanged", lock_loss_cnt);

    // 3: one-cycle glitch while qualifying lock
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    repeat (8) tick();
    expect_val(2); check("s3_state_stable", state_dbg);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    expect_val(2); check("s3_still_stable", state_dbg);
    tick();
    expect_val(1); check("s3_back_to_wait", state_dbg);
    expect_val(0); check("s3_sys_rst_n", sys_rst_n);
    expect_val(1); check("s3_loss_cnt_unchanged", lock_loss_cnt);
    expect_val(9);
    run_until(1'b1, 1'b1, n, saw);
    check("s3_release_latency", n);

    // 6: rst_n pulse in the middle of qualification
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    repeat (7) tick();
    expect_val(2); check("s6_state_stable", state_dbg);
    rst_n = 1'b0;
    tick();
    expect_val(1); check("s6_pll_rst", pll_rst);
    expect_val(0); check("s6_sys_rst_n", sys_rst_n);
    expect_val(0); check("s6_ready", ready);
    expect_val(0); check("s6_state", state_dbg);
    expect_val(0); check("s6_loss_cnt", lock_loss_cnt);
    expect_val(0); check("s6_tmo_cnt", timeout_cnt);
    rst_n    = 1'b1;
    pll_lock = 1'b0;

    // 2: PLL never locks
    for (int i = 1; i <= 2; i++) begin
      expect_val(4);
      run_until(1'b0, 1'b0, n, saw);
      check("s2_pll_rst_width", n);
      expect_val(32);
      run_until(1'b0, 1'b1, n, saw);
      check("s2_timeout_gap", n);
      expect_val(i);
      check("s2_tmo_cnt", timeout_cnt);
    end
    exp_tmo = 2;
    for (int i = 3; i <= 300; i++) begin
      run_until(1'b0, 1'b0, n, saw);
      run_until(1'b0, 1'b1, n, saw);
      exp_tmo = (exp_tmo == 255) ? 32'd255 : exp_tmo + 1;
      expect_val(exp_tmo);
      check("s2_tmo_sat", timeout_cnt);
    end
    expect_val(0); check("s2_sys_never_up", sys_rst_n);
    expect_val(0); check("s2_loss_cnt", lock_loss_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
